// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add 32x32 multiplier (low 32 product bits) that
// borrows the shared execute-stage ALU as its only adder/shifter.
// The multiplier is consumed LSB first; the loop stops as soon as the
// remaining multiplier bits are all zero, so latency depends on op_b only.
module alu_mul_seq #(
  parameter int         MAX_ITER = 32,
  parameter logic [2:0] OP_ADD   = 3'd0,
  parameter logic [2:0] OP_SLL   = 3'd6,
  parameter logic [2:0] OP_SRL   = 3'd7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic        alu_zero
);

  localparam logic [5:0] LP_MAX_ITER = 6'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_prod;
  logic [5:0]  r_iter;
  logic [31:0] r_result;

  // Drive the shared ALU from the current state; zeros whenever idle or done.
  always_comb begin
    alu_in1 = 32'd0;
    alu_in2 = 32'd0;
    alu_op  = 3'd0;
    case (r_state)
      S_CHECK: begin
        alu_in1 = r_mplier;
        alu_in2 = 32'd0;
        alu_op  = OP_ADD;
      end
      S_ADD: begin
        alu_in1 = r_prod;
        alu_in2 = r_mcand;
        alu_op  = OP_ADD;
      end
      S_SHL: begin
        alu_in1 = r_mcand;
        alu_in2 = 32'd1;
        alu_op  = OP_SLL;
      end
      S_SHR: begin
        alu_in1 = r_mplier;
        alu_in2 = 32'd1;
        alu_op  = OP_SRL;
      end
      default: begin
        alu_in1 = 32'd0;
        alu_in2 = 32'd0;
        alu_op  = 3'd0;
      end
    endcase
  end

  // Sequencer: captures operands, walks multiplier bits, registers ALU results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_prod   <= 32'd0;
      r_iter   <= 6'd0;
      r_result <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_prod   <= 32'd0;
            r_iter   <= 6'd0;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          // alu_zero here means the remaining multiplier is zero.
          if (alu_zero || (r_iter == LP_MAX_ITER)) begin
            r_result <= r_prod;
            r_state  <= S_DONE;
          end else if (r_mplier[0]) begin
            r_state <= S_ADD;
          end else begin
            r_state <= S_SHL;
          end
        end
        S_ADD: begin
          r_prod  <= alu_res;
          r_state <= S_SHL;
        end
        S_SHL: begin
          r_mcand <= alu_res;
          r_state <= S_SHR;
        end
        S_SHR: begin
          r_mplier <= alu_res;
          r_iter   <= r_iter + 6'd1;
          r_state  <= S_CHECK;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: bench for alu_mul_seq with a behavioural ALU, a
// cycle-level reference model of the multiplier, directed and random tests.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [2:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_zero;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  alu_mul_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_op   (alu_op),
    .alu_res  (alu_res),
    .alu_zero (alu_zero)
  );

  // Shared ALU stand-in
  always_comb begin
    case (alu_op)
      3'd0:    alu_res = alu_in1 + alu_in2;
      3'd6:    alu_res = alu_in1 << alu_in2[4:0];
      3'd7:    alu_res = alu_in1 >> alu_in2[4:0];
      default: alu_res = 32'd0;
    endcase
  end
  assign alu_zero = (alu_in1 == alu_in2);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle on which done rises: 3 cycles per multiplier bit up to the top set
  // bit, one extra per set bit, plus the final zero test and the done cycle.
  function automatic int lat_of(input logic [31:0] b);
    int k = 0;
    int p = 0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        k = i + 1;
        p++;
      end
    end
    return 3 * k + p + 2;
  endfunction

  // ALU opcode expected in cycle c (1-based, before done) for multiplier b:
  // each round is test(add), optional add, shift left, shift right.
  function automatic logic [2:0] op_of(input logic [31:0] b, input int c);
    logic [31:0] m = b;
    int n = 1;
    for (int it = 0; it < 40; it++) begin
      if (n == c) return 3'd0;
      if (m == 32'd0) return 3'd0;
      n++;
      if (m[0]) begin
        if (n == c) return 3'd0;
        n++;
      end
      if (n == c) return 3'd6;
      n++;
      if (n == c) return 3'd7;
      n++;
      m = m >> 1;
    end
    return 3'd0;
  endfunction

  // Reference model state
  logic        m_busy;
  int          m_cyc;
  int          m_lat;
  logic [31:0] m_pend;
  logic [31:0] m_res;
  logic [31:0] m_b;

  // Model advances one cycle per edge; reset clears it immediately.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cyc  <= 0;
      m_lat  <= 0;
      m_pend <= 32'd0;
      m_res  <= 32'd0;
      m_b    <= 32'd0;
    end else if (m_busy) begin
      if (m_cyc == m_lat) begin
        m_busy <= 1'b0;
      end else begin
        m_cyc <= m_cyc + 1;
        if (m_cyc + 1 == m_lat) m_res <= m_pend;
      end
    end else if (start) begin
      m_busy <= 1'b1;
      m_cyc  <= 1;
      m_lat  <= lat_of(op_b);
      m_pend <= op_a * op_b;
      m_b    <= op_b;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic       e_done;
      logic [2:0] e_op;
      e_done = m_busy && (m_cyc == m_lat);
      e_op   = (m_busy && !e_done) ? op_of(m_b, m_cyc) : 3'd0;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("result", result, m_res);
      chk("alu_op", 32'(alu_op), 32'(e_op));
      if (!m_busy || e_done) begin
        chk("alu_in1_quiet", alu_in1, 32'd0);
        chk("alu_in2_quiet", alu_in2, 32'd0);
      end
    end
  end

  logic [2:0] ops_seen [0:255];

  // Issue one multiply and wait for done; optional ignored start pulses.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_cyc,
                         input int p1, input int p2, output int cyc);
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 200) begin
      ops_seen[cyc-1] = alu_op;
      start = (cyc == p1 || cyc == p2);
      if (start) begin
        op_a = 32'd3;
        op_b = 32'd3;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", 32'(cyc), 32'(exp_cyc));
    chk("product", result, exp_res);
  endtask

  initial begin
    int cyc;
    logic [2:0] exp_ops [0:11];
    logic [31:0] ra, rb;
    exp_ops = '{3'd0, 3'd6, 3'd7, 3'd0, 3'd0, 3'd6, 3'd7, 3'd0, 3'd0, 3'd6, 3'd7, 3'd0};
    rst_n = 1'b1;
    start = 1'b0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_in1", alu_in1, 32'd0);
    chk("rst_in2", alu_in2, 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_mul(32'd7, 32'd0, 32'd0, 2, 0, 0, cyc);
    run_mul(32'd5, 32'd6, 32'd30, 13, 0, 0, cyc);
    for (int i = 0; i < 12; i++) chk("op_seq", 32'(ops_seen[i]), 32'(exp_ops[i]));
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 130, 0, 0, cyc);
    run_mul(32'h8000_0000, 32'd2, 32'd0, 9, 0, 0, cyc);

    // Starts during a busy multiply are ignored; the next IDLE start is taken.
    run_mul(32'd5, 32'd6, 32'd30, 13, 2, 4, cyc);
    run_mul(32'd3, 32'd3, 32'd9, 10, 0, 0, cyc);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'd9;
    op_b  = 32'hF0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_op", 32'(alu_op), 32'd0);
    chk("abort_in1", alu_in1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    run_mul(32'd9, 32'd2, 32'd18, 9, 0, 0, cyc);

    // Random operands; sparse multipliers exercise early termination.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 7 == 0) ra = 32'd0;
      run_mul(ra, rb, ra * rb, lat_of(rb), 0, 0, cyc);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
